mem_bus_arbiter: RTL and testbench

Parametrised N-port arbiter between private caches (L1I, L1D, prefetcher, …) and the shared L2 `mem_bus` interface. It grants the bus to one requester at a time and holds the grant until L2 returns `mem_ready`. Arbitration is fixed-priority or round-robin, and grants can be handed over back-to-back. A watchdog flags transactions that L2 never completes. It generalises the two-cache arbiter in front of L2.

---
 rtl/mem_bus_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// N-port arbiter between private caches and the shared L2 mem_bus. One owner at a time;
// the grant is held until L2 answers, with back-to-back handover and a sticky watchdog.
package mem_bus_pkg;
  localparam int LINE_BITS = 512;

  typedef struct packed {
    logic [57:0]          mem_addr;
    logic [LINE_BITS-1:0] mem_data_out;
    logic                 mem_req_load;
    logic                 mem_req_store;
  } mem_bus_req_t;

  typedef struct packed {
    logic [LINE_BITS-1:0] mem_data;
    logic                 mem_ready;
  } mem_bus_resp_t;
endpackage

module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NUM_PORTS       = 2,
  parameter int CACHE_LINE_SIZE = LINE_BITS,
  parameter bit RR_MODE         = 1'b1,
  parameter int TIMEOUT         = 1024
) (
  input  logic                         clock,
  input  logic                         reset,
  input  mem_bus_req_t                 req_in   [NUM_PORTS],
  output mem_bus_resp_t                resp_out [NUM_PORTS],
  output mem_bus_req_t                 req,
  input  mem_bus_resp_t                resp,
  output logic                         grant_valid,
  output logic [$clog2(NUM_PORTS)-1:0] grant_id,
  output logic                         timeout_err
);

  localparam int IDW = $clog2(NUM_PORTS);
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDW:0]   NP_V   = (IDW + 1)'(NUM_PORTS);
  localparam logic [IDW-1:0] LAST   = IDW'(NUM_PORTS - 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);

  // The struct line width lives in the package; the parameter must agree with it.
  if (CACHE_LINE_SIZE != LINE_BITS || NUM_PORTS < 2 || NUM_PORTS > 8) begin : g_bad_cfg
    $error("mem_bus_arbiter: unsupported NUM_PORTS/CACHE_LINE_SIZE");
  end

  logic                 grant_valid_q, grant_valid_d;
  logic [IDW-1:0]       grant_id_q, grant_id_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [WDW-1:0]       wd_cnt_q, wd_cnt_d;
  logic                 timeout_err_q, timeout_err_d;

  logic                 completing;
  logic                 any_eligible;
  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] ready_vec;
  logic [IDW-1:0]       next_grant;
  logic [IDW:0]         scan_sum;
  logic [IDW-1:0]       scan_idx;

  // A port finishing this cycle is masked so it cannot immediately re-own the bus.
  always_comb begin
    completing = grant_valid_q && resp.mem_ready;
    eligible   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      eligible[i] = (req_in[i].mem_req_load | req_in[i].mem_req_store) &&
                    !(completing && grant_id_q == IDW'(i));
    end
    any_eligible = |eligible;
  end

  // Scan in reverse so the last hit is the first port in priority order.
  always_comb begin
    next_grant = '0;
    scan_sum   = '0;
    scan_idx   = '0;
    if (RR_MODE) begin
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
        scan_sum = {1'b0, rr_ptr_q} + (IDW + 1)'(k);
        if (scan_sum >= NP_V) scan_sum = scan_sum - NP_V;
        scan_idx = scan_sum[IDW-1:0];
        if (eligible[scan_idx]) next_grant = scan_idx;
      end
    end else begin
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
        if (eligible[k]) next_grant = IDW'(k);
      end
    end
  end

  always_comb begin
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    if (!grant_valid_q) begin
      if (any_eligible) begin
        grant_valid_d = 1'b1;
        grant_id_d    = next_grant;
      end
    end else if (resp.mem_ready) begin
      rr_ptr_d = (grant_id_q == LAST) ? '0 : grant_id_q + 1'b1;
      if (any_eligible) begin
        grant_id_d = next_grant;
      end else begin
        grant_valid_d = 1'b0;
        grant_id_d    = '0;
      end
    end
  end

  // Counter restarts whenever ownership changes or L2 answers; saturates at TIMEOUT.
  always_comb begin
    wd_cnt_d      = wd_cnt_q;
    timeout_err_d = timeout_err_q;
    if (TIMEOUT > 0) begin
      if (!grant_valid_q || resp.mem_ready) begin
        wd_cnt_d = '0;
      end else if (wd_cnt_q != WD_MAX) begin
        wd_cnt_d = wd_cnt_q + 1'b1;
      end
      if (wd_cnt_d == WD_MAX) timeout_err_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      rr_ptr_q      <= '0;
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    req       = '0;
    ready_vec = '0;
    if (grant_valid_q) req = req_in[grant_id_q];
    for (int i = 0; i < NUM_PORTS; i++) begin
      resp_out[i] = '0;
      if (grant_valid_q && grant_id_q == IDW'(i) && resp.mem_ready) begin
        resp_out[i].mem_ready = 1'b1;
        resp_out[i].mem_data  = resp.mem_data;
        ready_vec[i]          = 1'b1;
      end
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign timeout_err = timeout_err_q;

  a_grant_id_range: assert property (@(posedge clock) disable iff (!reset)
    {1'b0, grant_id_q} < NP_V);
  a_one_ready: assert property (@(posedge clock) disable iff (!reset)
    $onehot0(ready_vec));
  a_ready_idle: assert property (@(posedge clock) disable iff (!reset)
    grant_valid_q || !resp.mem_ready)
    else $fatal(1, "mem_bus_arbiter: mem_ready while idle");

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a round-robin instance (4 ports, TIMEOUT=8) and a
// fixed-priority instance (4 ports, watchdog off), driven from a vector table plus sequences.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  localparam int NP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_bus_req_t  req_rr [NP];
  mem_bus_req_t  req_fp [NP];
  mem_bus_resp_t resp_out_rr [NP];
  mem_bus_resp_t resp_out_fp [NP];
  mem_bus_req_t  l2_req_rr, l2_req_fp;
  mem_bus_resp_t l2_resp_rr, l2_resp_fp;
  logic          gv_rr, gv_fp, to_rr, to_fp;
  logic [1:0]    gid_rr, gid_fp;

  mem_bus_arbiter #(.NUM_PORTS(NP), .CACHE_LINE_SIZE(512), .RR_MODE(1'b1), .TIMEOUT(8)) dut_rr (
    .clock(clk), .reset(rst_n), .req_in(req_rr), .resp_out(resp_out_rr), .req(l2_req_rr),
    .resp(l2_resp_rr), .grant_valid(gv_rr), .grant_id(gid_rr), .timeout_err(to_rr));

  mem_bus_arbiter #(.NUM_PORTS(NP), .CACHE_LINE_SIZE(512), .RR_MODE(1'b0), .TIMEOUT(0)) dut_fp (
    .clock(clk), .reset(rst_n), .req_in(req_fp), .resp_out(resp_out_fp), .req(l2_req_fp),
    .resp(l2_resp_fp), .grant_valid(gv_fp), .grant_id(gid_fp), .timeout_err(to_fp));

  typedef struct {
    logic       sel;    // 0 = round-robin instance, 1 = fixed-priority instance
    logic [3:0] ld;
    logic [3:0] st;
    logic       rdy;
    logic       gv;
    logic [1:0] gid;
    logic [3:0] rm;
    logic       rld;
    logic       rst;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int failures = 0;

  task automatic v(input logic sel, input logic [3:0] ld, input logic [3:0] st, input logic rdy,
                   input logic gv, input logic [1:0] gid, input logic [3:0] rm,
                   input logic rld, input logic rst);
    vec_t e;
    e.sel = sel; e.ld = ld; e.st = st; e.rdy = rdy;
    e.gv = gv; e.gid = gid; e.rm = rm; e.rld = rld; e.rst = rst;
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < NP; i++) begin
      req_rr[i] = '0;
      req_fp[i] = '0;
    end
    l2_resp_rr = '0;
    l2_resp_fp = '0;
  endtask

  task automatic drive(input logic sel, input logic [3:0] ld, input logic [3:0] st,
                       input logic rdy, input logic [511:0] data);
    clear_inputs();
    for (int i = 0; i < NP; i++) begin
      if (!sel) begin
        req_rr[i].mem_addr      = 58'h100 + 58'(i);
        req_rr[i].mem_data_out  = 512'(i + 7);
        req_rr[i].mem_req_load  = ld[i];
        req_rr[i].mem_req_store = st[i];
      end else begin
        req_fp[i].mem_addr      = 58'h100 + 58'(i);
        req_fp[i].mem_data_out  = 512'(i + 7);
        req_fp[i].mem_req_load  = ld[i];
        req_fp[i].mem_req_store = st[i];
      end
    end
    if (!sel) begin
      l2_resp_rr.mem_ready = rdy;
      l2_resp_rr.mem_data  = data;
    end else begin
      l2_resp_fp.mem_ready = rdy;
      l2_resp_fp.mem_data  = data;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [511:0] data;
    logic [511:0] line;
    logic [3:0]   rm_act;
    mem_bus_req_t  l2_act;
    mem_bus_resp_t ro;
    logic         gv_act, to_act;
    logic [1:0]   gid_act;
    vec_t         e;
    logic         exp_gv;

    // Round-robin: all four hold loads, L2 answers 3 cycles after each grant (rows start at cycle 1).
    for (int r = 0; r < 5; r++) begin
      v(0, 4'hF, 4'h0, 0, 1, 2'(r % 4), 4'h0, 1, 0);
      v(0, 4'hF, 4'h0, 0, 1, 2'(r % 4), 4'h0, 1, 0);
      v(0, 4'hF, 4'h0, 0, 1, 2'(r % 4), 4'h0, 1, 0);
      v(0, 4'hF, 4'h0, 1, 1, 2'(r % 4), 4'(1 << (r % 4)), 1, 0);
    end
    // Completion masking: lone requester keeps store high in its ready cycle.
    v(0, 4'h0, 4'h2, 1, 1, 2'd1, 4'h2, 0, 1);
    v(0, 4'h0, 4'h0, 0, 0, 2'd0, 4'h0, 0, 0);
    v(0, 4'h0, 4'h2, 0, 0, 2'd0, 4'h0, 0, 0);
    v(0, 4'h0, 4'h2, 1, 1, 2'd1, 4'h2, 0, 1);
    v(0, 4'h0, 4'h0, 0, 0, 2'd0, 4'h0, 0, 0);
    // Pointer now 2: ports 1 and 2 contend, 2 wins, then single-cycle alternation.
    v(0, 4'h6, 4'h0, 0, 0, 2'd0, 4'h0, 0, 0);
    v(0, 4'h6, 4'h0, 1, 1, 2'd2, 4'h4, 1, 0);
    v(0, 4'h6, 4'h0, 1, 1, 2'd1, 4'h2, 1, 0);
    v(0, 4'h0, 4'h0, 1, 1, 2'd2, 4'h4, 0, 0);
    v(0, 4'h0, 4'h0, 0, 0, 2'd0, 4'h0, 0, 0);
    // Fixed priority instance.
    v(1, 4'h5, 4'h0, 0, 0, 2'd0, 4'h0, 0, 0);
    v(1, 4'h5, 4'h0, 1, 1, 2'd0, 4'h1, 1, 0);
    v(1, 4'h4, 4'h0, 0, 1, 2'd2, 4'h0, 1, 0);
    v(1, 4'hF, 4'h0, 1, 1, 2'd2, 4'h4, 1, 0);
    v(1, 4'hE, 4'h0, 1, 1, 2'd0, 4'h1, 0, 0);
    v(1, 4'hE, 4'h0, 1, 1, 2'd1, 4'h2, 1, 0);
    v(1, 4'h0, 4'h0, 1, 1, 2'd2, 4'h4, 0, 0);
    v(1, 4'hC, 4'h0, 0, 0, 2'd0, 4'h0, 0, 0);
    v(1, 4'h0, 4'h0, 1, 1, 2'd2, 4'h4, 0, 0);
    v(1, 4'h0, 4'h0, 0, 0, 2'd0, 4'h0, 0, 0);

    // Reset held with every port requesting.
    clear_inputs();
    drive(0, 4'hF, 4'h0, 0, '0);
    for (int i = 0; i < NP; i++) req_fp[i].mem_req_load = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_gv_rr", gv_rr, 0);
    chk("rst_gv_fp", gv_fp, 0);
    chk("rst_req_load", l2_req_rr.mem_req_load, 0);
    chk("rst_req_zero", l2_req_rr, '0);
    chk("rst_resp_ready", resp_out_rr[0].mem_ready, 0);
    chk("rst_timeout", to_rr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NP; i++) req_fp[i] = '0;

    for (int r = 0; r < tbl.size(); r++) begin
      e = tbl[r];
      data = '0;
      data[511:496] = 16'hA5A5;
      data[15:0]    = 16'(r);
      next_cycle();
      drive(e.sel, e.ld, e.st, e.rdy, data);
      #1;
      gv_act  = e.sel ? gv_fp : gv_rr;
      gid_act = e.sel ? gid_fp : gid_rr;
      to_act  = e.sel ? to_fp : to_rr;
      l2_act  = e.sel ? l2_req_fp : l2_req_rr;
      for (int i = 0; i < NP; i++) begin
        ro = e.sel ? resp_out_fp[i] : resp_out_rr[i];
        rm_act[i] = ro.mem_ready;
        chk($sformatf("r%0d_data_p%0d", r, i), ro.mem_data, e.rm[i] ? data : '0);
      end
      chk($sformatf("r%0d_grant_valid", r), gv_act, e.gv);
      chk($sformatf("r%0d_grant_id", r), gid_act, e.gid);
      chk($sformatf("r%0d_ready_mask", r), rm_act, e.rm);
      chk($sformatf("r%0d_req_load", r), l2_act.mem_req_load, e.rld);
      chk($sformatf("r%0d_req_store", r), l2_act.mem_req_store, e.rst);
      chk($sformatf("r%0d_req_addr", r), l2_act.mem_addr, e.gv ? 58'h100 + 58'(e.gid) : 58'h0);
      chk($sformatf("r%0d_req_wdata", r), l2_act.mem_data_out, e.gv ? 512'(e.gid + 7) : 512'h0);
      chk($sformatf("r%0d_timeout", r), to_act, 0);
    end

    // Data routing: port 3 loads 0x2A, L2 returns a marked line on the third granted cycle.
    line = '0;
    line[511:496] = 16'hDEAD;
    line[15:0]    = 16'hBEEF;
    next_cycle();
    clear_inputs();
    for (int i = 0; i < NP; i++) req_rr[i].mem_addr = 58'h100 + 58'(i);
    req_rr[3].mem_addr     = 58'h2A;
    req_rr[3].mem_req_load = 1'b1;
    l2_resp_rr.mem_data    = line;
    #1;
    chk("route_idle_gv", gv_rr, 0);
    chk("route_idle_addr", l2_req_rr.mem_addr, 0);
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      l2_resp_rr.mem_ready = (c == 3);
      #1;
      chk($sformatf("route_c%0d_gv", c), gv_rr, 1);
      chk($sformatf("route_c%0d_gid", c), gid_rr, 3);
      chk($sformatf("route_c%0d_addr", c), l2_req_rr.mem_addr, 58'h2A);
      for (int i = 0; i < NP; i++) begin
        chk($sformatf("route_c%0d_data_p%0d", c, i), resp_out_rr[i].mem_data,
            (c == 3 && i == 3) ? line : '0);
        chk($sformatf("route_c%0d_rdy_p%0d", c, i), resp_out_rr[i].mem_ready, c == 3 && i == 3);
      end
    end
    next_cycle();
    clear_inputs();
    #1;
    chk("route_done_gv", gv_rr, 0);
    chk("route_done_addr", l2_req_rr.mem_addr, 0);

    // Watchdog: L2 silent for 9 granted cycles, answers in the 10th, port 0 re-requests.
    next_cycle();
    req_rr[0].mem_req_load = 1'b1;
    req_fp[0].mem_req_load = 1'b1;
    #1;
    chk("wd_start_gv", gv_rr, 0);
    for (int w = 1; w <= 12; w++) begin
      next_cycle();
      l2_resp_rr.mem_ready = (w == 10);
      l2_resp_fp.mem_ready = (w == 10);
      #1;
      exp_gv = (w != 11);
      chk($sformatf("wd_w%0d_gv", w), gv_rr, exp_gv);
      chk($sformatf("wd_w%0d_timeout", w), to_rr, w >= 9);
      chk($sformatf("wd_w%0d_timeout_off", w), to_fp, 0);
    end

    // Asynchronous reset mid-cycle while port 0 owns the bus.
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_gv", gv_rr, 0);
    chk("areset_gid", gid_rr, 0);
    chk("areset_timeout", to_rr, 0);
    chk("areset_req", l2_req_rr, '0);
    chk("areset_resp_p0", resp_out_rr[0], '0);
    chk("areset_gv_fp", gv_fp, 0);
    next_cycle();
    #1;
    chk("areset_hold_gv", gv_rr, 0);
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
